// File: rtl/dcsk_modem_gen2.sv
// rtl/dcsk_modem_gen2.sv - parametrised DCSK modem core (chaotic-reference transmitter and correlating receiver)

module dcsk_modem_gen2 #(
    parameter int          SAMPLE_W    = 8,
    parameter int          SF_MIN_LOG2 = 3,
    parameter int          SF_SEL_W    = 2,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          CORR_W      = 2*SAMPLE_W + SF_MIN_LOG2 + (1 << SF_SEL_W) - 1
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic [SF_SEL_W-1:0]        Spread_Factor_Sel,
    input  logic                       Tx_Bit,
    input  logic                       Tx_Valid,
    output logic                       Tx_Ready,
    output logic signed [SAMPLE_W-1:0] Tx_Chip,
    output logic                       Tx_Chip_Valid,
    input  logic signed [SAMPLE_W-1:0] Rx_Chip,
    input  logic                       Rx_Chip_Valid,
    input  logic                       Rx_Flush,
    output logic                       Rx_Bit,
    output logic                       Rx_Bit_Valid,
    output logic signed [CORR_W-1:0]   Rx_Corr
);

    // Chip index width covers the largest spreading factor; the reference buffer is that deep.
    localparam int IDX_W  = SF_MIN_LOG2 + (1 << SF_SEL_W) - 1;
    localparam int DEPTH  = 1 << IDX_W;
    localparam int PROD_W = 2*SAMPLE_W;

    localparam logic signed [SAMPLE_W-1:0] CHIP_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic signed [SAMPLE_W-1:0] CHIP_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};

    typedef enum logic [1:0] {TX_IDLE, TX_REF, TX_DATA} tx_state_e;
    typedef enum logic       {R_REF, R_DATA}            rx_state_e;

    // One step of the right-shifting Galois chaos generator.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Index of the last chip in a half-symbol for a given SF select.
    function automatic logic [IDX_W-1:0] last_idx(input logic [SF_SEL_W-1:0] sel);
        logic [IDX_W:0] sf;
        logic [IDX_W:0] m;
        sf = (IDX_W+1)'(1) << (SF_MIN_LOG2 + int'(sel));
        m  = sf - (IDX_W+1)'(1);
        return m[IDX_W-1:0];
    endfunction

    // Negation that maps the most negative chip to the most positive one instead of wrapping.
    function automatic logic signed [SAMPLE_W-1:0] neg_sat(input logic signed [SAMPLE_W-1:0] x);
        if (x == CHIP_MIN) begin
            return CHIP_MAX;
        end
        return -x;
    endfunction

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_e        tx_state_q, tx_state_d;
    logic [IDX_W-1:0] tx_idx_q,   tx_idx_d;
    logic [IDX_W-1:0] tx_last_q,  tx_last_d;
    logic             tx_bit_q,   tx_bit_d;
    logic [15:0]      lfsr_q,     lfsr_d;
    logic [15:0]      replay_q,   replay_d;

    // TX state register; reset abandons any symbol in flight.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            tx_state_q <= TX_IDLE;
            tx_idx_q   <= '0;
            tx_last_q  <= '0;
            tx_bit_q   <= 1'b0;
            lfsr_q     <= LFSR_SEED;
            replay_q   <= LFSR_SEED;
        end else begin
            tx_state_q <= tx_state_d;
            tx_idx_q   <= tx_idx_d;
            tx_last_q  <= tx_last_d;
            tx_bit_q   <= tx_bit_d;
            lfsr_q     <= lfsr_d;
            replay_q   <= replay_d;
        end
    end

    // TX next state: the main LFSR advances only on reference chips; the replay copy
    // re-walks the same sequence during the data half.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_idx_d   = tx_idx_q;
        tx_last_d  = tx_last_q;
        tx_bit_d   = tx_bit_q;
        lfsr_d     = lfsr_q;
        replay_d   = replay_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (Tx_Valid) begin
                    tx_state_d = TX_REF;
                    tx_bit_d   = Tx_Bit;
                    tx_last_d  = last_idx(Spread_Factor_Sel);
                    tx_idx_d   = '0;
                    replay_d   = lfsr_q;
                end
            end
            TX_REF: begin
                lfsr_d = lfsr_step(lfsr_q);
                if (tx_idx_q == tx_last_q) begin
                    tx_state_d = TX_DATA;
                    tx_idx_d   = '0;
                end else begin
                    tx_idx_d = tx_idx_q + 1'b1;
                end
            end
            TX_DATA: begin
                replay_d = lfsr_step(replay_q);
                if (tx_idx_q == tx_last_q) begin
                    tx_state_d = TX_IDLE;
                    tx_idx_d   = '0;
                end else begin
                    tx_idx_d = tx_idx_q + 1'b1;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
            end
        endcase
    end

    // TX outputs decoded straight from state so reset silences the chip stream at once.
    always_comb begin
        Tx_Ready      = (tx_state_q == TX_IDLE);
        Tx_Chip_Valid = (tx_state_q != TX_IDLE);
        Tx_Chip       = '0;
        case (tx_state_q)
            TX_REF:  Tx_Chip = lfsr_q[SAMPLE_W-1:0];
            TX_DATA: Tx_Chip = tx_bit_q ? replay_q[SAMPLE_W-1:0] : neg_sat(replay_q[SAMPLE_W-1:0]);
            default: Tx_Chip = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    rx_state_e                 rx_state_q, rx_state_d;
    logic [IDX_W-1:0]          rx_idx_q,   rx_idx_d;
    logic [IDX_W-1:0]          rx_last_q,  rx_last_d;
    logic signed [CORR_W-1:0]  acc_q,      acc_d;
    logic                      rx_bit_q,   rx_bit_d;
    logic                      rx_bitv_q,  rx_bitv_d;
    logic signed [CORR_W-1:0]  corr_q,     corr_d;

    logic                      buf_we;
    logic signed [SAMPLE_W-1:0] ref_buf [DEPTH];
    logic signed [SAMPLE_W-1:0] ref_rd;
    logic signed [PROD_W-1:0]  prod;
    logic signed [CORR_W-1:0]  acc_next;
    logic [IDX_W-1:0]          last_cur;

    assign ref_rd   = ref_buf[rx_idx_q];
    assign prod     = ref_rd * Rx_Chip;
    assign acc_next = ((rx_idx_q == '0) ? '0 : acc_q)
                    + {{(CORR_W-PROD_W){prod[PROD_W-1]}}, prod};

    // Reference chip buffer; contents are only meaningful once rewritten for the current symbol.
    always_ff @(posedge Clk) begin
        if (buf_we) begin
            ref_buf[rx_idx_q] <= Rx_Chip;
        end
    end

    // RX state register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rx_state_q <= R_REF;
            rx_idx_q   <= '0;
            rx_last_q  <= '0;
            acc_q      <= '0;
            rx_bit_q   <= 1'b0;
            rx_bitv_q  <= 1'b0;
            corr_q     <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_idx_q   <= rx_idx_d;
            rx_last_q  <= rx_last_d;
            acc_q      <= acc_d;
            rx_bit_q   <= rx_bit_d;
            rx_bitv_q  <= rx_bitv_d;
            corr_q     <= corr_d;
        end
    end

    // RX next state: only valid chips advance; flush wins over a coincident chip.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_idx_d   = rx_idx_q;
        rx_last_d  = rx_last_q;
        acc_d      = acc_q;
        rx_bit_d   = rx_bit_q;
        rx_bitv_d  = 1'b0;
        corr_d     = corr_q;
        buf_we     = 1'b0;
        last_cur   = (rx_idx_q == '0) ? last_idx(Spread_Factor_Sel) : rx_last_q;
        if (Rx_Flush) begin
            rx_state_d = R_REF;
            rx_idx_d   = '0;
            acc_d      = '0;
        end else if (Rx_Chip_Valid) begin
            case (rx_state_q)
                R_REF: begin
                    buf_we    = 1'b1;
                    rx_last_d = last_cur;
                    if (rx_idx_q == last_cur) begin
                        rx_state_d = R_DATA;
                        rx_idx_d   = '0;
                    end else begin
                        rx_idx_d = rx_idx_q + 1'b1;
                    end
                end
                R_DATA: begin
                    acc_d = acc_next;
                    if (rx_idx_q == rx_last_q) begin
                        rx_state_d = R_REF;
                        rx_idx_d   = '0;
                        rx_bitv_d  = 1'b1;
                        rx_bit_d   = ~acc_next[CORR_W-1];
                        corr_d     = acc_next;
                    end else begin
                        rx_idx_d = rx_idx_q + 1'b1;
                    end
                end
                default: begin
                    rx_state_d = R_REF;
                    rx_idx_d   = '0;
                end
            endcase
        end
    end

    assign Rx_Bit       = rx_bit_q;
    assign Rx_Bit_Valid = rx_bitv_q;
    assign Rx_Corr      = corr_q;

endmodule

// File: tb/tb_dcsk_modem_gen2.sv
// tb/tb_dcsk_modem_gen2.sv - directed self-checking bench for dcsk_modem_gen2

module tb_dcsk_modem_gen2;

    logic Clk;
    logic Rst;

    logic [1:0]        sel;
    logic              tx_bit, tx_valid, tx_ready, tx_chip_valid;
    logic signed [7:0] tx_chip;
    logic signed [7:0] rx_chip, rx_chip_drv;
    logic              rx_valid, rx_valid_drv, rx_flush;
    logic              rx_bit, rx_bit_valid;
    logic signed [21:0] rx_corr;
    logic              loop_en;

    logic [1:0]        s_sel;
    logic              s_tx_bit, s_tx_valid, s_tx_ready, s_tx_chip_valid;
    logic signed [7:0] s_tx_chip;
    logic              s_rx_bit, s_rx_bit_valid;
    logic signed [21:0] s_rx_corr;

    int n_cmp;
    int n_bad;

    logic [15:0]       m_lfsr;
    logic signed [7:0] cap [128];
    logic signed [21:0] last_exp_corr;

    assign rx_chip  = loop_en ? tx_chip       : rx_chip_drv;
    assign rx_valid = loop_en ? tx_chip_valid : rx_valid_drv;

    dcsk_modem_gen2 dut (
        .Clk(Clk), .Rst(Rst), .Spread_Factor_Sel(sel),
        .Tx_Bit(tx_bit), .Tx_Valid(tx_valid), .Tx_Ready(tx_ready),
        .Tx_Chip(tx_chip), .Tx_Chip_Valid(tx_chip_valid),
        .Rx_Chip(rx_chip), .Rx_Chip_Valid(rx_valid), .Rx_Flush(rx_flush),
        .Rx_Bit(rx_bit), .Rx_Bit_Valid(rx_bit_valid), .Rx_Corr(rx_corr)
    );

    dcsk_modem_gen2 #(.LFSR_SEED(16'h0080)) dut_sat (
        .Clk(Clk), .Rst(Rst), .Spread_Factor_Sel(s_sel),
        .Tx_Bit(s_tx_bit), .Tx_Valid(s_tx_valid), .Tx_Ready(s_tx_ready),
        .Tx_Chip(s_tx_chip), .Tx_Chip_Valid(s_tx_chip_valid),
        .Rx_Chip(8'sd0), .Rx_Chip_Valid(1'b0), .Rx_Flush(1'b0),
        .Rx_Bit(s_rx_bit), .Rx_Bit_Valid(s_rx_bit_valid), .Rx_Corr(s_rx_corr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [15:0] m_step(input logic [15:0] s);
        logic [15:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    // Sends one symbol, checks every chip against the model and the end-of-symbol timing.
    task automatic tx_symbol(input logic b, input logic [1:0] s, input bit rx_loop);
        int sf;
        int corr;
        logic signed [7:0] refv [64];
        logic signed [7:0] datv [64];
        logic signed [7:0] exp_c;
        sf = 1 << (3 + int'(s));
        corr = 0;
        for (int k = 0; k < sf; k++) begin
            refv[k] = m_lfsr[7:0];
            m_lfsr  = m_step(m_lfsr);
            if (b) datv[k] = refv[k];
            else if (refv[k] == 8'sh80) datv[k] = 8'sh7F;
            else datv[k] = -refv[k];
            corr += int'(refv[k]) * int'(datv[k]);
        end
        last_exp_corr = 22'(corr);
        @(negedge Clk);
        n_cmp++;
        if (tx_ready !== 1'b1) begin
            n_bad++; $display("FAIL tx_ready_before_symbol: got %b expected 1", tx_ready);
        end
        tx_valid = 1'b1; tx_bit = b; sel = s;
        @(negedge Clk);
        tx_valid = 1'b0;
        for (int k = 0; k < 2*sf; k++) begin
            if (k > 0) @(negedge Clk);
            exp_c  = (k < sf) ? refv[k] : datv[k-sf];
            cap[k] = tx_chip;
            n_cmp++;
            if (tx_chip_valid !== 1'b1 || tx_chip !== exp_c || tx_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL tx_chip[%0d]: got v=%b chip=%h rdy=%b expected v=1 chip=%h rdy=0",
                         k, tx_chip_valid, tx_chip, tx_ready, exp_c);
            end
            if (rx_loop) begin
                n_cmp++;
                if (rx_bit_valid !== 1'b0) begin
                    n_bad++; $display("FAIL rx_early_strobe[%0d]: got %b expected 0", k, rx_bit_valid);
                end
            end
        end
        @(negedge Clk);
        n_cmp++;
        if (tx_ready !== 1'b1 || tx_chip_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL tx_end: got rdy=%b v=%b expected rdy=1 v=0", tx_ready, tx_chip_valid);
        end
        if (rx_loop) begin
            n_cmp++;
            if (rx_bit_valid !== 1'b1 || rx_bit !== b || rx_corr !== last_exp_corr) begin
                n_bad++;
                $display("FAIL rx_symbol: got v=%b bit=%b corr=%0d expected v=1 bit=%b corr=%0d",
                         rx_bit_valid, rx_bit, rx_corr, b, last_exp_corr);
            end
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        repeat (3) @(negedge Clk);
        n_cmp++;
        if (tx_ready !== 1'b1 || tx_chip !== 8'sd0 || tx_chip_valid !== 1'b0 ||
            rx_bit !== 1'b0 || rx_bit_valid !== 1'b0 || rx_corr !== 22'sd0) begin
            n_bad++;
            $display("FAIL reset_values: got rdy=%b chip=%h v=%b bit=%b bv=%b corr=%0d expected 1 00 0 0 0 0",
                     tx_ready, tx_chip, tx_chip_valid, rx_bit, rx_bit_valid, rx_corr);
        end
        Rst = 1'b0;
        m_lfsr = 16'hACE1;
        @(negedge Clk);
        n_cmp++;
        if (tx_ready !== 1'b1 || tx_chip_valid !== 1'b0 || rx_bit_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_idle: got rdy=%b v=%b bv=%b expected 1 0 0", tx_ready, tx_chip_valid, rx_bit_valid);
        end
    endtask

    task automatic test_loopback();
        logic bits [4];
        bits[0] = 1'b1; bits[1] = 1'b0; bits[2] = 1'b1; bits[3] = 1'b1;
        loop_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tx_symbol(bits[i], 2'd0, 1'b1);
            if (i == 0) begin
                n_cmp++;
                if (cap[0] !== 8'shE1 || cap[1] !== 8'sh70) begin
                    n_bad++;
                    $display("FAIL first_chips: got %h %h expected e1 70", cap[0], cap[1]);
                end
            end
            n_cmp++;
            if ((bits[i] && !(rx_corr > 0)) || (!bits[i] && !(rx_corr < 0))) begin
                n_bad++; $display("FAIL corr_sign[%0d]: got %0d for bit %b", i, rx_corr, bits[i]);
            end
        end
    endtask

    task automatic test_sf64();
        loop_en = 1'b1;
        tx_symbol(1'b0, 2'd3, 1'b1);
    endtask

    task automatic test_saturation();
        logic signed [21:0] exp_corr;
        exp_corr = -22'sd130048;
        loop_en = 1'b0;
        sel = 2'd0;
        for (int i = 0; i < 16; i++) begin
            @(negedge Clk);
            n_cmp++;
            if (rx_bit_valid !== 1'b0) begin
                n_bad++; $display("FAIL sat_rx_early[%0d]: got %b expected 0", i, rx_bit_valid);
            end
            rx_chip_drv  = (i < 8) ? 8'sh80 : 8'sh7F;
            rx_valid_drv = 1'b1;
        end
        @(negedge Clk);
        rx_valid_drv = 1'b0;
        n_cmp++;
        if (rx_bit_valid !== 1'b1 || rx_bit !== 1'b0 || rx_corr !== exp_corr) begin
            n_bad++;
            $display("FAIL sat_rx_corr: got v=%b bit=%b corr=%0d expected v=1 bit=0 corr=%0d",
                     rx_bit_valid, rx_bit, rx_corr, exp_corr);
        end
        @(negedge Clk);
        n_cmp++;
        if (rx_bit_valid !== 1'b0 || rx_corr !== exp_corr) begin
            n_bad++;
            $display("FAIL sat_rx_hold: got v=%b corr=%0d expected v=0 corr=%0d", rx_bit_valid, rx_corr, exp_corr);
        end
        s_tx_valid = 1'b1; s_tx_bit = 1'b0; s_sel = 2'd0;
        @(negedge Clk);
        s_tx_valid = 1'b0;
        n_cmp++;
        if (s_tx_chip_valid !== 1'b1 || s_tx_chip !== 8'sh80) begin
            n_bad++; $display("FAIL sat_tx_ref0: got v=%b chip=%h expected v=1 chip=80", s_tx_chip_valid, s_tx_chip);
        end
        repeat (8) @(negedge Clk);
        n_cmp++;
        if (s_tx_chip_valid !== 1'b1 || s_tx_chip !== 8'sh7F) begin
            n_bad++; $display("FAIL sat_tx_data0: got v=%b chip=%h expected v=1 chip=7f", s_tx_chip_valid, s_tx_chip);
        end
        repeat (10) @(negedge Clk);
    endtask

    task automatic test_sel_change();
        logic signed [7:0] ra [8];
        logic signed [7:0] rb [32];
        logic signed [7:0] exp_c;
        logic signed [7:0] d;
        int corr_a, corr_b;
        corr_a = 0; corr_b = 0;
        for (int k = 0; k < 8; k++) begin
            ra[k] = m_lfsr[7:0]; m_lfsr = m_step(m_lfsr);
            corr_a += int'(ra[k]) * int'(ra[k]);
        end
        for (int k = 0; k < 32; k++) begin
            rb[k] = m_lfsr[7:0]; m_lfsr = m_step(m_lfsr);
            d = (rb[k] == 8'sh80) ? 8'sh7F : -rb[k];
            corr_b += int'(rb[k]) * int'(d);
        end
        loop_en = 1'b1;
        @(negedge Clk);
        tx_valid = 1'b1; tx_bit = 1'b1; sel = 2'd0;
        @(negedge Clk);
        tx_bit = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge Clk);
            if (k == 1) sel = 2'd2;
            exp_c = (k < 8) ? ra[k] : ra[k-8];
            n_cmp++;
            if (tx_chip_valid !== 1'b1 || tx_chip !== exp_c) begin
                n_bad++; $display("FAIL selchg_sym1[%0d]: got v=%b chip=%h expected v=1 chip=%h", k, tx_chip_valid, tx_chip, exp_c);
            end
        end
        @(negedge Clk);
        n_cmp++;
        if (tx_chip_valid !== 1'b0 || tx_ready !== 1'b1 || rx_bit_valid !== 1'b1 || rx_bit !== 1'b1 ||
            rx_corr !== 22'(corr_a)) begin
            n_bad++;
            $display("FAIL selchg_sym1_end: got v=%b rdy=%b bv=%b bit=%b corr=%0d expected 0 1 1 1 %0d",
                     tx_chip_valid, tx_ready, rx_bit_valid, rx_bit, rx_corr, corr_a);
        end
        @(negedge Clk);
        tx_valid = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (k > 0) @(negedge Clk);
            if (k < 32) exp_c = rb[k];
            else exp_c = (rb[k-32] == 8'sh80) ? 8'sh7F : -rb[k-32];
            n_cmp++;
            if (tx_chip_valid !== 1'b1 || tx_chip !== exp_c) begin
                n_bad++; $display("FAIL selchg_sym2[%0d]: got v=%b chip=%h expected v=1 chip=%h", k, tx_chip_valid, tx_chip, exp_c);
            end
        end
        @(negedge Clk);
        n_cmp++;
        if (tx_chip_valid !== 1'b0 || rx_bit_valid !== 1'b1 || rx_bit !== 1'b0 || rx_corr !== 22'(corr_b)) begin
            n_bad++;
            $display("FAIL selchg_sym2_end: got v=%b bv=%b bit=%b corr=%0d expected 0 1 0 %0d",
                     tx_chip_valid, rx_bit_valid, rx_bit, rx_corr, corr_b);
        end
    endtask

    task automatic test_gaps();
        logic bits [2];
        bits[0] = 1'b0; bits[1] = 1'b1;
        loop_en = 1'b0;
        rx_valid_drv = 1'b0;
        for (int b = 0; b < 2; b++) begin
            tx_symbol(bits[b], 2'd1, 1'b0);
            sel = 2'd1;
            for (int i = 0; i < 32; i++) begin
                @(negedge Clk);
                rx_chip_drv = cap[i]; rx_valid_drv = 1'b1;
                @(negedge Clk);
                rx_valid_drv = 1'b0;
                n_cmp++;
                if (i < 31) begin
                    if (rx_bit_valid !== 1'b0) begin
                        n_bad++; $display("FAIL gap_early_strobe[%0d]: got %b expected 0", i, rx_bit_valid);
                    end
                end else if (rx_bit_valid !== 1'b1 || rx_bit !== bits[b] || rx_corr !== last_exp_corr) begin
                    n_bad++;
                    $display("FAIL gap_decode[%0d]: got v=%b bit=%b corr=%0d expected v=1 bit=%b corr=%0d",
                             b, rx_bit_valid, rx_bit, rx_corr, bits[b], last_exp_corr);
                end
            end
            @(negedge Clk);
            n_cmp++;
            if (rx_bit_valid !== 1'b0) begin
                n_bad++; $display("FAIL gap_strobe_width[%0d]: got %b expected 0", b, rx_bit_valid);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic signed [7:0] r [8];
        r[0] = 8'sd10; r[1] = -8'sd20; r[2] = 8'sd30; r[3] = -8'sd40;
        r[4] = 8'sd50; r[5] = -8'sd60; r[6] = 8'sd70; r[7] = -8'sd80;
        loop_en = 1'b1;
        @(negedge Clk);
        tx_valid = 1'b1; tx_bit = 1'b1; sel = 2'd0;
        @(negedge Clk);
        tx_valid = 1'b0;
        repeat (10) @(negedge Clk);
        #2 Rst = 1'b1;
        #1;
        n_cmp++;
        if (tx_chip_valid !== 1'b0 || tx_ready !== 1'b1 || rx_corr !== 22'sd0) begin
            n_bad++;
            $display("FAIL async_reset: got v=%b rdy=%b corr=%0d expected 0 1 0", tx_chip_valid, tx_ready, rx_corr);
        end
        @(negedge Clk);
        Rst = 1'b0;
        m_lfsr = 16'hACE1;
        tx_symbol(1'b1, 2'd0, 1'b1);
        n_cmp++;
        if (cap[0] !== 8'shE1) begin
            n_bad++; $display("FAIL reset_restart_chip: got %h expected e1", cap[0]);
        end
        loop_en = 1'b0;
        sel = 2'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            rx_chip_drv = 8'(i + 1); rx_valid_drv = 1'b1;
        end
        @(negedge Clk);
        rx_flush = 1'b1; rx_chip_drv = 8'sd99; rx_valid_drv = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge Clk);
            rx_flush = 1'b0;
            n_cmp++;
            if (rx_bit_valid !== 1'b0) begin
                n_bad++; $display("FAIL flush_spurious[%0d]: got %b expected 0", i, rx_bit_valid);
            end
            rx_chip_drv  = (i < 8) ? r[i] : -r[i-8];
            rx_valid_drv = 1'b1;
        end
        @(negedge Clk);
        rx_valid_drv = 1'b0;
        n_cmp++;
        if (rx_bit_valid !== 1'b1 || rx_bit !== 1'b0 || rx_corr !== -22'sd20400) begin
            n_bad++;
            $display("FAIL flush_decode: got v=%b bit=%b corr=%0d expected v=1 bit=0 corr=-20400",
                     rx_bit_valid, rx_bit, rx_corr);
        end
        @(negedge Clk);
        n_cmp++;
        if (rx_bit_valid !== 1'b0 || rx_corr !== -22'sd20400) begin
            n_bad++; $display("FAIL flush_hold: got v=%b corr=%0d expected v=0 corr=-20400", rx_bit_valid, rx_corr);
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        Rst = 1'b1;
        sel = 2'd0; tx_bit = 1'b0; tx_valid = 1'b0;
        rx_chip_drv = 8'sd0; rx_valid_drv = 1'b0; rx_flush = 1'b0; loop_en = 1'b0;
        s_sel = 2'd0; s_tx_bit = 1'b0; s_tx_valid = 1'b0;
        m_lfsr = 16'hACE1;
        last_exp_corr = '0;
        test_reset();
        test_loopback();
        test_sf64();
        test_saturation();
        test_sel_change();
        test_gaps();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dcsk_modem_gen2.md
Name: dcsk_modem_gen2

Overview:
Parametrised DCSK modem core: a transmitter and a receiver sharing one clock and one reset.
- Transmitter spreads each data bit over a runtime-selectable spreading factor SF. It uses a chaotic (LFSR-derived) reference half followed by a data half, where the data half is the reference (bit=1) or its negation (bit=0).
- Receiver buffers the reference half, correlates it against the data half and decides the bit from the correlation sign.
- Generalises the fixed-format modem to configurable sample width, SF range, LFSR seed, input handshake, correlation export and resync.

Parameters:
SAMPLE_W, 8, signed chip width in bits.
SF_MIN_LOG2, 3, log2 of smallest spreading factor.
SF_SEL_W, 2, width of Spread_Factor_Sel; SF = 2^(SF_MIN_LOG2 + sel), so the default range is 8..64.
LFSR_SEED, 16'hACE1, reset value of the 16-bit chaos LFSR; must be nonzero.
CORR_W, 2*SAMPLE_W + SF_MIN_LOG2 + 2^SF_SEL_W - 1, correlator accumulator width (derived; do not override).

Ports:
Clk  in  1  system clock, rising edge.
Rst  in  1  asynchronous, active-high reset.
Spread_Factor_Sel  in  SF_SEL_W  SF select, sampled at each symbol start.
Tx_Bit  in  1  data bit to modulate.
Tx_Valid  in  1  Tx_Bit valid.
Tx_Ready  out  1  transmitter can accept a bit.
Tx_Chip  out  SAMPLE_W  signed output chip.
Tx_Chip_Valid  out  1  Tx_Chip valid.
Rx_Chip  in  SAMPLE_W  signed received chip.
Rx_Chip_Valid  in  1  Rx_Chip valid.
Rx_Flush  in  1  synchronous receiver resync; the next valid chip is treated as reference chip 0.
Rx_Bit  out  1  demodulated bit.
Rx_Bit_Valid  out  1  one-cycle strobe for Rx_Bit.
Rx_Corr  out  CORR_W  signed correlation of the last symbol.

Behaviour:
Clock and reset
- One clock (Clk); reset Rst is asynchronous and active-high.
- While Rst is high, all state returns to reset immediately, including mid-symbol. No partial symbol resumes after reset.
- Reset values: Tx_Ready=1, Tx_Chip=0, Tx_Chip_Valid=0, Rx_Bit=0, Rx_Bit_Valid=0, Rx_Corr=0, LFSR=LFSR_SEED, TX FSM=IDLE, RX FSM=R_REF with count 0.

Chaos LFSR
- 16-bit Galois LFSR, shift right: next = (s>>1) ^ (s[0] ? 16'hB400 : 0).
- Reference chip = signed s[SAMPLE_W-1:0].
- Main LFSR steps once per reference chip only.

TX FSM: IDLE -> REF -> DATA -> IDLE
- IDLE: Tx_Ready=1. Tx_Valid&&Tx_Ready in cycle t accepts the bit and latches Tx_Bit and Spread_Factor_Sel; SF is fixed for the whole symbol. Save LFSR state to replay register; go to REF.
- REF: SF cycles, one chip per cycle from t+1, Tx_Chip_Valid=1, Tx_Ready=0.
- DATA: SF cycles. The replay register steps identically to the main LFSR, so data chip k uses the same value as reference chip k. Output is the value for bit=1, or its negation for bit=0. Negation of -2^(SAMPLE_W-1) saturates to 2^(SAMPLE_W-1)-1.
- After the last data chip (cycle t+2SF) return to IDLE. Tx_Ready=1 at t+2SF+1; the earliest next first chip is at t+2SF+2.
- No backpressure on chips.
- Spread_Factor_Sel changes mid-symbol are ignored.

RX FSM: R_REF -> R_DATA -> R_REF
- Only cycles with Rx_Chip_Valid=1 advance; gaps of any length are allowed.
- R_REF: latch SF from Spread_Factor_Sel at chip 0. Store chips 0..SF-1 in a buffer of depth 2^(SF_MIN_LOG2+2^SF_SEL_W-1).
- R_DATA: accumulate ref[k]*Rx_Chip as a signed full-precision product. The accumulator is cleared at data chip 0 and cannot overflow at CORR_W.
- On the cycle after the last data chip:
  - Rx_Bit_Valid=1 for one cycle.
  - Rx_Bit = (corr >= 0).
  - Rx_Corr = corr, held until the next symbol completes.
  - Return to R_REF.
- Rx_Flush: the counter returns to R_REF chip 0 and the accumulator clears; no strobe is emitted. Rx_Flush together with Rx_Chip_Valid in the same cycle discards that chip.
- A TX and RX symbol overlapping (loopback) is legal; the two are independent.

Test Plan:
1. Loopback Tx_Chip->Rx_Chip, sel=0 (SF=8), bits 1,0,1,1 -> expected response:
   - first Tx_Chip = 8'hE1 (-31), second = 8'h70 (112);
   - 16 chips per bit;
   - Rx_Bit_Valid pulses 4 times with bits 1,0,1,1, each 1 cycle after its 16th chip;
   - Rx_Corr >0 for 1, <0 for 0.
2. Single bit 0, sel=3 (SF=64) -> 128 contiguous chips; data chip k = -ref chip k; Tx_Ready low for 128 cycles, high at t+129.
3. Drive Rx with ref chips all -128 and data chips all 127, SF=8 -> Rx_Corr = -130048, Rx_Bit=0. Force TX replay value 8'h80 with bit 0 -> Tx_Chip=8'h7F.
4. Change Spread_Factor_Sel 0->2 during TX REF of an SF=8 symbol -> symbol stays 16 chips; next symbol is 64 chips.
5. Rx_Chip_Valid toggling 1/0 every cycle in loopback with delayed chips, SF=16 -> same bits decoded; strobe only after the 32nd valid chip.
6. Assert Rst asynchronously mid-DATA:
   - Tx_Chip_Valid drops immediately.
   - After release, the first chip is again 8'hE1.
   - Rx_Flush mid-symbol then clean symbol -> correct bit, no spurious strobe.
